// File: rtl/isr_autopush.sv
// Parametrised input shift register with autopush threshold, explicit PUSH and a
// single-entry push slot toward the RX FIFO. Define ISR_BITREV_EN to add push_rev.
module isr_autopush #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             penable,
    input  logic             op_set,
    input  logic             op_push,
    input  logic             op_shift,
    input  logic [WIDTH-1:0] din,
    input  logic [CW-1:0]    shift_amt,
    input  logic             dir,
    input  logic             autopush,
    input  logic [CW-1:0]    thresh,
    input  logic             push_iffull,
    input  logic             push_block,
`ifdef ISR_BITREV_EN
    input  logic             push_rev,
`endif
    output logic             stall,
    output logic [WIDTH-1:0] dout,
    output logic [CW:0]      count,
    output logic             push_valid,
    output logic [WIDTH-1:0] push_data,
    input  logic             push_ready
);

    localparam logic [CW:0]   FULL  = (CW+1)'(WIDTH);
    localparam logic [CW+1:0] FULL2 = (CW+2)'(WIDTH);

    logic [WIDTH-1:0]   shift_reg;
    logic [CW:0]        n, t;
    logic [CW+1:0]      sum;
    logic [CW:0]        cnt_nxt;
    logic [2*WIDTH-1:0] cat_sh;
    logic [WIDTH-1:0]   mask, next_reg;
    logic               slot_free, load;
    logic [WIDTH-1:0]   load_val, slot_val, reg_d;
    logic [CW:0]        cnt_d;

    assign dout = shift_reg;

    // Zero in the shift and threshold fields both encode a full word.
    assign n = (shift_amt == '0) ? FULL : {1'b0, shift_amt};
    assign t = (thresh == '0) ? FULL : {1'b0, thresh};

    assign sum     = {1'b0, count} + {1'b0, n};
    assign cnt_nxt = (sum >= FULL2) ? FULL : sum[CW:0];

    assign cat_sh = {din, shift_reg} >> n;
    assign mask   = ~({WIDTH{1'b1}} << n);

    always_comb begin
        if (dir) next_reg = cat_sh[WIDTH-1:0];
        else     next_reg = (shift_reg << n) | (din & mask);
    end

    // The slot can be drained and refilled on the same edge.
    assign slot_free = !push_valid || push_ready;

    always_comb begin
        stall    = 1'b0;
        load     = 1'b0;
        load_val = shift_reg;
        reg_d    = shift_reg;
        cnt_d    = count;
        if (penable) begin
            if (op_set) begin
                reg_d = din;
                cnt_d = '0;
            end else if (op_push) begin
                if (!(push_iffull && (count < t))) begin
                    if (slot_free) begin
                        load     = 1'b1;
                        load_val = shift_reg;
                        reg_d    = '0;
                        cnt_d    = '0;
                    end else if (push_block) begin
                        stall = 1'b1;
                    end else begin
                        reg_d = '0;
                        cnt_d = '0;
                    end
                end
            end else if (op_shift) begin
                if (!autopush || (cnt_nxt < t)) begin
                    reg_d = next_reg;
                    cnt_d = cnt_nxt;
                end else if (slot_free) begin
                    load     = 1'b1;
                    load_val = next_reg;
                    reg_d    = '0;
                    cnt_d    = '0;
                end else begin
                    stall = 1'b1;
                end
            end
        end
    end

`ifdef ISR_BITREV_EN
    always_comb begin
        slot_val = load_val;
        if (push_rev)
            for (int i = 0; i < WIDTH; i++) slot_val[i] = load_val[WIDTH-1-i];
    end
`else
    assign slot_val = load_val;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_reg  <= '0;
            count      <= '0;
            push_valid <= 1'b0;
            push_data  <= '0;
        end else begin
            shift_reg <= reg_d;
            count     <= cnt_d;
            if (load) begin
                push_valid <= 1'b1;
                push_data  <= slot_val;
            end else if (push_valid && push_ready) begin
                push_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_isr_autopush.sv
// Randomised scoreboard bench for isr_autopush (WIDTH=32): an arithmetic reference
// model predicts state and queues expected pushes; a monitor checks each handshake.
module tb_isr_autopush;

    logic        clk = 1'b0;
    logic        reset_n, penable, op_set, op_push, op_shift, dir, autopush;
    logic        push_iffull, push_block, push_ready;
    logic [31:0] din;
    logic [4:0]  shift_amt, thresh;
    logic        stall, push_valid;
    logic [31:0] dout, push_data;
    logic [5:0]  count;
`ifdef ISR_BITREV_EN
    logic        push_rev = 1'b0;
`endif

    always #5 clk = ~clk;

    isr_autopush #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .penable(penable),
        .op_set(op_set), .op_push(op_push), .op_shift(op_shift),
        .din(din), .shift_amt(shift_amt), .dir(dir), .autopush(autopush),
        .thresh(thresh), .push_iffull(push_iffull), .push_block(push_block),
`ifdef ISR_BITREV_EN
        .push_rev(push_rev),
`endif
        .stall(stall), .dout(dout), .count(count),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready)
    );

    int passed = 0;
    int total  = 0;

    longint unsigned m_reg = 0;
    int              m_cnt = 0;
    longint unsigned sbq[$];
    logic            last_stall;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Every RX FIFO handshake must deliver the oldest predicted push.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && push_valid === 1'b1 && push_ready === 1'b1) begin
            if (sbq.size() == 0) chk("unexpected_push", {32'd0, push_data}, 64'hx);
            else chk("push_handshake", {32'd0, push_data}, sbq.pop_front());
        end
    end

    task automatic idle();
        op_set = 0; op_push = 0; op_shift = 0; penable = 1;
    endtask

    // Called 2 time units after a rising edge with inputs already applied.
    task automatic step();
        longint unsigned p, nr, nc, lv, new_reg;
        int   n, T, new_cnt;
        logic sf, ld, es;
        #1;
        n  = (shift_amt == 0) ? 32 : int'(shift_amt);
        T  = (thresh == 0) ? 32 : int'(thresh);
        sf = (sbq.size() == 0) || push_ready;
        es = 0; ld = 0; lv = 0; nr = 0;
        new_reg = m_reg; new_cnt = m_cnt;
        if (penable) begin
            if (op_set) begin
                new_reg = din; new_cnt = 0;
            end else if (op_push) begin
                if (!(push_iffull && m_cnt < T)) begin
                    if (sf) begin ld = 1; lv = m_reg; new_reg = 0; new_cnt = 0; end
                    else if (push_block) es = 1;
                    else begin new_reg = 0; new_cnt = 0; end
                end
            end else if (op_shift) begin
                p = 64'd1 << n;
                if (dir) nr = (din % p) * (64'd1 << (32 - n)) + m_reg / p;
                else     nr = (m_reg * p + din % p) % (64'd1 << 32);
                nc = (m_cnt + n > 32) ? 32 : m_cnt + n;
                if (!autopush || nc < T) begin new_reg = nr; new_cnt = int'(nc); end
                else if (sf) begin ld = 1; lv = nr; new_reg = 0; new_cnt = 0; end
                else es = 1;
            end
        end
        last_stall = stall;
        chk("stall", {63'd0, stall}, {63'd0, es});
        chk("dout", {32'd0, dout}, m_reg);
        chk("count", {58'd0, count}, 64'(m_cnt));
        chk("push_valid", {63'd0, push_valid}, {63'd0, sbq.size() > 0});
        if (sbq.size() > 0) chk("push_data_hold", {32'd0, push_data}, sbq[0]);
        @(posedge clk);
        if (!reset_n) begin
            m_reg = 0; m_cnt = 0; sbq.delete();
        end else begin
            m_reg = new_reg; m_cnt = new_cnt;
            if (ld) sbq.push_back(lv);
        end
        #2;
    endtask

    task automatic shift_op(input logic [31:0] d, input logic [4:0] a);
        idle(); op_shift = 1; din = d; shift_amt = a; step();
    endtask

    initial begin
        reset_n = 0; idle(); din = 0; shift_amt = 0; dir = 0; autopush = 0;
        thresh = 0; push_iffull = 0; push_block = 0; push_ready = 0;
        repeat (2) @(posedge clk);
        #2; reset_n = 1;

        // Reset in the middle of a shift sequence
        shift_op(32'hA5A5_1234, 5'd8);
        shift_op(32'h0000_00FF, 5'd4);
        idle(); reset_n = 0; step(); step(); reset_n = 1;
        chk("rst_dout", {32'd0, dout}, 64'd0);
        chk("rst_count", {58'd0, count}, 64'd0);
        chk("rst_valid", {63'd0, push_valid}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);

        // Left shift, no autopush, then a full-width shift saturating count
        dir = 0; autopush = 0;
        repeat (3) shift_op(32'h5, 5'd4);
        chk("left_dout", {32'd0, dout}, 64'h555);
        chk("left_count", {58'd0, count}, 64'd12);
        shift_op(32'hDEAD_BEEF, 5'd0);
        chk("full_dout", {32'd0, dout}, 64'hDEAD_BEEF);
        chk("full_count", {58'd0, count}, 64'd32);

        // Right shift autopush at threshold 8
        idle(); op_set = 1; din = 0; step();
        dir = 1; autopush = 1; thresh = 5'd8; push_ready = 1;
        repeat (4) shift_op(32'h3, 5'd2);
        chk("ap_valid", {63'd0, push_valid}, 64'd1);
        chk("ap_data", {32'd0, push_data}, 64'hFF00_0000);
        chk("ap_count", {58'd0, count}, 64'd0);
        chk("ap_dout", {32'd0, dout}, 64'd0);

        // Backpressure: threshold reached with a busy slot
        push_ready = 0;
        repeat (3) shift_op(32'h1, 5'd2);
        shift_op(32'h1, 5'd2);
        chk("bp_stall", {63'd0, last_stall}, 64'd1);
        chk("bp_hold", {58'd0, count}, 64'd6);
        push_ready = 1;
        shift_op(32'h1, 5'd2);
        chk("bp_release", {63'd0, last_stall}, 64'd0);
        chk("bp_valid", {63'd0, push_valid}, 64'd1);
        chk("bp_data", {32'd0, push_data}, 64'h5500_0000);

        // PUSH variants against a busy slot
        push_ready = 0; autopush = 0;
        shift_op(32'hF, 5'd4);
        idle(); op_push = 1; push_block = 1; step();
        chk("push_block", {63'd0, last_stall}, 64'd1);
        chk("push_block_cnt", {58'd0, count}, 64'd4);
        idle(); op_push = 1; push_block = 0; step();
        chk("push_drop_cnt", {58'd0, count}, 64'd0);
        chk("push_drop_data", {32'd0, push_data}, 64'h5500_0000);
        shift_op(32'hF, 5'd4);
        idle(); op_push = 1; push_iffull = 1; thresh = 5'd8; step();
        chk("iffull_cnt", {58'd0, count}, 64'd4);
        chk("iffull_stall", {63'd0, last_stall}, 64'd0);
        push_iffull = 0;

        // Priority and penable gating
        idle(); op_set = 1; op_shift = 1; din = 32'h1234_5678; step();
        chk("prio_dout", {32'd0, dout}, 64'h1234_5678);
        chk("prio_count", {58'd0, count}, 64'd0);
        idle(); penable = 0; op_shift = 1; op_push = 1; push_block = 1; step();
        chk("pen_stall", {63'd0, last_stall}, 64'd0);
        chk("pen_dout", {32'd0, dout}, 64'h1234_5678);
        idle(); push_ready = 1; step();

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            reset_n     = ($urandom_range(0, 299) != 0);
            penable     = ($urandom_range(0, 9) != 0);
            op_set      = ($urandom_range(0, 15) == 0);
            op_push     = ($urandom_range(0, 5) == 0);
            op_shift    = ($urandom_range(0, 2) != 0);
            din         = $urandom;
            shift_amt   = 5'($urandom);
            thresh      = 5'($urandom);
            dir         = 1'($urandom);
            autopush    = ($urandom_range(0, 9) < 7);
            push_iffull = 1'($urandom);
            push_block  = 1'($urandom);
            push_ready  = ($urandom_range(0, 9) < 6);
            step();
        end
        reset_n = 1; idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
